incline_filter: RTL

- Conditions raw 13-bit signed incline samples from the inertial sensor path before they reach the incline saturation stage.
- On each valid strobe, updates a first-order exponential (IIR) average and presents the filtered 13-bit incline downstream.
- Flags a stale-data condition when samples stop arriving. Sits directly upstream of the incline saturator; its incline output feeds that block's 13-bit input unchanged.

---
 rtl/incline_pkg.sv | 6 +
 rtl/incline_filter_stale_timer.sv | 22 ++
 rtl/incline_filter.sv | 46 ++++
 3 files changed

// File: rtl/incline_pkg.sv
// incline_pkg: shared incline types used by the filter and the saturation stage.
package incline_pkg;
  localparam int INCLINE_W = 13;
  typedef enum logic {EMPTY, TRACK} incl_filt_state_t;
  typedef logic signed [INCLINE_W-1:0] incline_t;
endpackage

// File: rtl/incline_filter_stale_timer.sv
// stale_timer: saturating idle-cycle counter with a registered stale flag.
module stale_timer #(
  parameter int STALE_CYCLES = 1048576
) (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe,
  output logic stale
);
  localparam int CW = $clog2(STALE_CYCLES + 1);
  logic [CW-1:0] cnt, cnt_nxt;
  // A strobe clears the count within its own cycle, so the register holds idle cycles since it.
  always_comb cnt_nxt = strobe ? CW'(1) : (cnt == CW'(STALE_CYCLES) ? cnt : cnt + CW'(1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt   <= '0;
      stale <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      stale <= cnt_nxt == CW'(STALE_CYCLES);
    end
endmodule

// File: rtl/incline_filter.sv
// incline_filter: first-order IIR average of raw incline samples with a stale-data flag.
module incline_filter
  import incline_pkg::*;
#(
  parameter int FILT_SHIFT   = 4,
  parameter int STALE_CYCLES = 1048576
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic signed [INCLINE_W-1:0] incline_raw,
  input  logic                        incline_vld,
  output logic signed [INCLINE_W-1:0] incline,
  output logic                        filt_vld,
  output logic                        stale
);
  localparam int AW = INCLINE_W + 1 + FILT_SHIFT;
  incl_filt_state_t state;
  logic signed [AW-1:0] accum, accum_nxt, raw_ext;
  stale_timer #(.STALE_CYCLES(STALE_CYCLES)) u_stale (
    .clk(clk),
    .rst_n(rst_n),
    .strobe(incline_vld),
    .stale(stale)
  );
  always_comb begin
    raw_ext   = AW'(incline_raw);
    accum_nxt = (state == EMPTY || stale) ? raw_ext <<< FILT_SHIFT
                                          : accum - (accum >>> FILT_SHIFT) + raw_ext;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      accum    <= '0;
      incline  <= '0;
      filt_vld <= 1'b0;
      state    <= EMPTY;
    end else begin
      filt_vld <= incline_vld;
      if (incline_vld) begin
        accum   <= accum_nxt;
        incline <= accum_nxt[FILT_SHIFT +: INCLINE_W];
        state   <= TRACK;
      end else if (stale) begin
        state <= EMPTY;
      end
    end
endmodule
